// File: rtl/posit_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : posit_mac_pkg
//  Description : Shared types and helpers for the posit MAC sequencer:
//                FSM state encoding, lane slice helper, posit constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package posit_mac_pkg;

    // Sequencer states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIAS  = 3'd1,
        ST_ACC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_REQ   = 3'd4,
        ST_WAIT  = 3'd5,
        ST_OUT   = 3'd6,
        ST_CLR   = 3'd7
    } seq_state_t;

    // Widest posit lane the helpers below are meant to cover
    localparam int unsigned c_max_n = 32;

    // Posit zero is all-zero bits at every width
    localparam logic [c_max_n-1:0] c_posit_zero = '0;

    // NaR: sign bit set, everything else clear, for an n-bit posit
    function automatic logic [c_max_n-1:0] posit_nar(input int unsigned n);
        logic [c_max_n-1:0] v;
        v = c_posit_zero;
        v[n-1] = 1'b1;
        return v;
    endfunction

    // Bit offset of a lane inside a CH*N packed bus
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned n);
        return lane * n;
    endfunction

    // Counter width needed to hold values 0..v (never less than one bit)
    function automatic int unsigned cnt_width(input int unsigned v);
        if (v < 2) begin
            return 1;
        end
        return $clog2(v + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/posit_mac_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module      : posit_mac_seq_timer
//  Description : Loadable down-counter with a done flag. Shared by the
//                sequencer for the quire-settle and result-latency waits.
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_mac_seq_timer #(
    parameter int unsigned W = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Load wins over counting; the counter parks at zero once expired
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/posit_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : posit_mac_seq
//  Description : Dot-product sequencer for CH parallel posit MAC lanes.
//                Takes a back-pressured operand stream, issues bias load,
//                accumulate, result request and purge strobes with fixed
//                latency-aware timing, and holds lane results until taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_mac_seq
    import posit_mac_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned CH      = 4,
    parameter int unsigned LEN_W   = 13,
    parameter int unsigned ACC_LAT = 3,
    parameter int unsigned RES_LAT = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [LEN_W-1:0]  CFG_LEN,
    input  logic              CFG_BIAS_EN,
    input  logic [CH*N-1:0]   BIAS,
    output logic              BUSY,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [CH*N-1:0]   S_IN1,
    input  logic [CH*N-1:0]   S_IN2,
    output logic [CH*N-1:0]   MAC_IN1,
    output logic [CH*N-1:0]   MAC_IN2,
    output logic [CH*N-1:0]   MAC_BIAS,
    output logic              MAC_EN,
    output logic              BIAS_EN,
    output logic              RESULT_REQ_PLS,
    output logic              PURGE,
    input  logic [CH*N-1:0]   MAC_OUT,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [CH*N-1:0]   M_DATA
);

    // One timer serves both waits, so size it for the longer one
    localparam int unsigned c_tmr_max = (ACC_LAT > RES_LAT) ? ACC_LAT : RES_LAT;
    localparam int unsigned c_tmr_w   = cnt_width(c_tmr_max);

    // DRAIN spans the final MAC_EN cycle plus ACC_LAT further cycles
    localparam logic [c_tmr_w-1:0] c_drain_load = c_tmr_w'(ACC_LAT);
    // WAIT spans RES_LAT cycles; capture happens in its last cycle
    localparam logic [c_tmr_w-1:0] c_wait_load  = (RES_LAT > 0) ? c_tmr_w'(RES_LAT - 1) : '0;

    localparam logic [CH*N-1:0] c_lane_zero = {CH{c_posit_zero[N-1:0]}};

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;

    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic [CH*N-1:0]     r_mac_in1;
    logic [CH*N-1:0]     r_mac_in2;
    logic [CH*N-1:0]     r_mac_bias;
    logic                r_mac_en;
    logic                r_bias_en;
    logic                r_req_pls;
    logic                r_purge;
    logic                r_s_ready;
    logic                r_busy;
    logic                r_m_valid;
    logic [CH*N-1:0]     r_m_data;

    logic                w_hs;
    logic                w_last;
    logic                w_tmr_load;
    logic [c_tmr_w-1:0]  w_tmr_val;
    logic                w_tmr_en;
    logic                w_tmr_done;

    // S_READY is only ever high in ACC, so this is the accepted-beat strobe
    assign w_hs     = S_VALID & r_s_ready;
    assign w_last   = (r_cnt == (r_len - LEN_W'(1)));
    assign w_tmr_en = (r_state == ST_DRAIN) || (r_state == ST_WAIT);

    posit_mac_seq_timer #(
        .W (c_tmr_w)
    ) u_timer (
        .CLK        (CLK),
        .RESET      (RESET),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_done     (w_tmr_done)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and timer loading on entry to DRAIN / WAIT
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = c_drain_load;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    if (CFG_BIAS_EN) begin
                        w_state_nxt = ST_BIAS;
                    end else if (CFG_LEN != '0) begin
                        w_state_nxt = ST_ACC;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                        w_tmr_load  = 1'b1;
                    end
                end
            end
            ST_BIAS: begin
                if (r_len != '0) begin
                    w_state_nxt = ST_ACC;
                end else begin
                    w_state_nxt = ST_DRAIN;
                    w_tmr_load  = 1'b1;
                end
            end
            ST_ACC: begin
                if (w_hs && w_last) begin
                    w_state_nxt = ST_DRAIN;
                    w_tmr_load  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_state_nxt = ST_WAIT;
                w_tmr_load  = 1'b1;
                w_tmr_val   = c_wait_load;
            end
            ST_WAIT: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (M_READY) begin
                    w_state_nxt = ST_CLR;
                end
            end
            ST_CLR: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Job configuration latched when a job is accepted
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_len      <= '0;
            r_mac_bias <= c_lane_zero;
        end else if ((r_state == ST_IDLE) && START) begin
            r_len      <= CFG_LEN;
            r_mac_bias <= BIAS;
        end
    end

    // Beat counter and operand registers; operands hold through bubbles
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_cnt     <= '0;
            r_mac_in1 <= c_lane_zero;
            r_mac_in2 <= c_lane_zero;
        end else begin
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
            if (w_hs) begin
                r_mac_in1 <= S_IN1;
                r_mac_in2 <= S_IN2;
            end
        end
    end

    // Registered strobes and status; each strobe is tied to a distinct state
    // or to the beat before it, so at most one can be high per cycle
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_mac_en  <= 1'b0;
            r_bias_en <= 1'b0;
            r_req_pls <= 1'b0;
            r_purge   <= 1'b0;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_mac_en  <= w_hs;
            r_bias_en <= (w_state_nxt == ST_BIAS);
            r_req_pls <= (w_state_nxt == ST_REQ);
            r_purge   <= (w_state_nxt == ST_CLR);
            r_s_ready <= (w_state_nxt == ST_ACC);
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    // Result holding register: capture in the last WAIT cycle, release on handshake
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_m_valid <= 1'b0;
            r_m_data  <= c_lane_zero;
        end else if ((r_state == ST_WAIT) && w_tmr_done) begin
            r_m_valid <= 1'b1;
            for (int unsigned l = 0; l < CH; l++) begin
                r_m_data[lane_lsb(l, N) +: N] <= MAC_OUT[lane_lsb(l, N) +: N];
            end
        end else if ((r_state == ST_OUT) && M_READY) begin
            r_m_valid <= 1'b0;
        end
    end

    assign BUSY           = r_busy;
    assign S_READY        = r_s_ready;
    assign MAC_IN1        = r_mac_in1;
    assign MAC_IN2        = r_mac_in2;
    assign MAC_BIAS       = r_mac_bias;
    assign MAC_EN         = r_mac_en;
    assign BIAS_EN        = r_bias_en;
    assign RESULT_REQ_PLS = r_req_pls;
    assign PURGE          = r_purge;
    assign M_VALID        = r_m_valid;
    assign M_DATA         = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_posit_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_posit_mac_seq
//  Description : Self-checking bench for posit_mac_seq with four behavioural
//                posit8 (es=1) MAC lanes and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_mac_seq;
    import posit_mac_pkg::*;

    localparam int unsigned N       = 8;
    localparam int unsigned CH      = 4;
    localparam int unsigned LEN_W   = 13;
    localparam int unsigned ACC_LAT = 3;
    localparam int unsigned RES_LAT = 2;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              START = 1'b0;
    logic [LEN_W-1:0]  CFG_LEN = '0;
    logic              CFG_BIAS_EN = 1'b0;
    logic [CH*N-1:0]   BIAS = '0;
    logic              BUSY;
    logic              S_VALID = 1'b0;
    logic              S_READY;
    logic [CH*N-1:0]   S_IN1 = '0;
    logic [CH*N-1:0]   S_IN2 = '0;
    logic [CH*N-1:0]   MAC_IN1, MAC_IN2, MAC_BIAS;
    logic              MAC_EN, BIAS_EN, RESULT_REQ_PLS, PURGE;
    logic [CH*N-1:0]   MAC_OUT;
    logic              M_VALID;
    logic              M_READY = 1'b0;
    logic [CH*N-1:0]   M_DATA;

    int errors = 0;
    int checks = 0;

    logic [CH*N-1:0] sb_q [$];

    // per-job statistics gathered by the monitor
    int cyc_no = 0;
    int j_mac, j_bias, j_req, j_purge, j_busy, j_first_mac, j_bias_cyc;

    always #5 CLK = ~CLK;

    posit_mac_seq #(
        .N(N), .CH(CH), .LEN_W(LEN_W), .ACC_LAT(ACC_LAT), .RES_LAT(RES_LAT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .CFG_LEN(CFG_LEN),
        .CFG_BIAS_EN(CFG_BIAS_EN), .BIAS(BIAS), .BUSY(BUSY),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_IN1(S_IN1), .S_IN2(S_IN2),
        .MAC_IN1(MAC_IN1), .MAC_IN2(MAC_IN2), .MAC_BIAS(MAC_BIAS),
        .MAC_EN(MAC_EN), .BIAS_EN(BIAS_EN), .RESULT_REQ_PLS(RESULT_REQ_PLS),
        .PURGE(PURGE), .MAC_OUT(MAC_OUT), .M_VALID(M_VALID),
        .M_READY(M_READY), .M_DATA(M_DATA)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // posit8, es=1 -> real
    function automatic real p8_dec(input logic [7:0] p);
        logic [7:0] v;
        int i, k, e;
        real f, w, r;
        if (p == 8'h00 || p == 8'h80) return 0.0;
        v = p[7] ? (~p + 8'd1) : p;
        i = 6;
        if (v[6]) begin
            k = -1;
            while (i >= 0 && v[i]) begin k++; i--; end
        end else begin
            k = 0;
            while (i >= 0 && !v[i]) begin k--; i--; end
        end
        i--;
        e = 0;
        if (i >= 0) begin e = int'(v[i]); i--; end
        f = 1.0;
        w = 0.5;
        for (int j = i; j >= 0; j--) begin
            if (v[j]) f += w;
            w = w / 2.0;
        end
        r = f;
        e = 2 * k + e;
        if (e >= 0) for (int j = 0; j < e; j++) r = r * 2.0;
        else        for (int j = 0; j < -e; j++) r = r / 2.0;
        return p[7] ? -r : r;
    endfunction

    // real -> nearest posit8 code, by exhaustive search
    function automatic logic [7:0] p8_enc(input real x);
        logic [7:0] best, c;
        real bd, d;
        best = 8'h00;
        bd = (x < 0.0) ? -x : x;
        for (int i = 1; i < 256; i++) begin
            c = 8'(i);
            if (c != 8'h80) begin
                d = p8_dec(c) - x;
                if (d < 0.0) d = -d;
                if (d < bd) begin bd = d; best = c; end
            end
        end
        return best;
    endfunction

    // Behavioural lanes: quire in real arithmetic, RES_LAT=2 output pipeline
    real q [CH];
    logic [CH*N-1:0] res1, res2;
    assign MAC_OUT = res2;

    always @(posedge CLK) begin
        if (!RESET) begin
            for (int l = 0; l < CH; l++) q[l] <= 0.0;
            res1 <= '0;
            res2 <= '0;
        end else begin
            for (int l = 0; l < CH; l++) begin
                if (PURGE)        q[l] <= 0.0;
                else if (BIAS_EN) q[l] <= p8_dec(MAC_BIAS[l*N +: N]);
                else if (MAC_EN)  q[l] <= q[l] + p8_dec(MAC_IN1[l*N +: N]) * p8_dec(MAC_IN2[l*N +: N]);
                if (RESULT_REQ_PLS) res1[l*N +: N] <= p8_enc(q[l]);
            end
            res2 <= res1;
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on result handshake
    logic            prev_hs = 1'b0, prev_mhs = 1'b0, prev_hold = 1'b0;
    logic [CH*N-1:0] prev_data = '0;
    always @(negedge CLK) begin
        if (!RESET) begin
            prev_hs   = 1'b0;
            prev_mhs  = 1'b0;
            prev_hold = 1'b0;
        end else begin
            cyc_no++;
            check("mac_en_follows_beat", 64'(MAC_EN), 64'(prev_hs));
            check("purge_after_handshake", 64'(PURGE), 64'(prev_mhs));
            check("one_strobe", 64'($countones({MAC_EN, BIAS_EN, RESULT_REQ_PLS, PURGE}) <= 1), 64'(1));
            if (prev_hold) begin
                check("m_valid_hold", 64'(M_VALID), 64'(1));
                check("m_data_hold", 64'(M_DATA), 64'(prev_data));
            end
            j_mac   += int'(MAC_EN);
            j_bias  += int'(BIAS_EN);
            j_req   += int'(RESULT_REQ_PLS);
            j_purge += int'(PURGE);
            j_busy  += int'(BUSY);
            if (MAC_EN && j_first_mac < 0) j_first_mac = cyc_no;
            if (BIAS_EN) j_bias_cyc = cyc_no;
            if (M_VALID && M_READY) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected no result", M_DATA);
                end else begin
                    check("m_data", 64'(M_DATA), 64'(sb_q.pop_front()));
                end
            end
            prev_hs   = S_VALID && S_READY;
            prev_mhs  = M_VALID && M_READY;
            prev_hold = M_VALID && !M_READY;
            prev_data = M_DATA;
        end
    end

    task automatic run_job(input string nm, input int len, input bit ben, input logic [7:0] bias,
                           input bit toggle, input int mhold, input bit start_in_hold,
                           input int abort_after, input logic [CH*N-1:0] exp_data, input int exp_busy);
        int cyc, outc, acc;
        bit done, aborted;
        if (abort_after == 0) sb_q.push_back(exp_data);
        j_mac = 0; j_bias = 0; j_req = 0; j_purge = 0; j_busy = 0;
        j_first_mac = -1; j_bias_cyc = -1;
        CFG_LEN = LEN_W'(len);
        CFG_BIAS_EN = ben;
        BIAS = {CH{bias}};
        M_READY = (mhold == 0);
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        cyc = 0; outc = 0; acc = 0; done = 1'b0; aborted = 1'b0;
        while (!done) begin
            S_VALID = toggle ? (cyc % 2 == 0) : 1'b1;
            S_IN1 = S_VALID ? {CH{8'h40}} : {CH{8'h7F}};
            S_IN2 = S_VALID ? {CH{8'h40}} : {CH{8'h7F}};
            @(negedge CLK); #1;
            if (!BUSY) begin
                done = 1'b1;
            end else begin
                if (S_VALID && S_READY) acc++;
                if (M_VALID) outc++;
                cyc++;
                @(posedge CLK); #1;
                START = start_in_hold && (outc >= 2) && (outc <= 4);
                M_READY = (outc >= mhold);
                if (abort_after > 0 && acc == abort_after) begin
                    S_VALID = 1'b0;
                    RESET = 1'b0;
                    @(posedge CLK); #1;
                    RESET = 1'b1;
                    @(negedge CLK); #1;
                    check({nm, "_ctrl_zero"}, 64'({BUSY, S_READY, MAC_EN, BIAS_EN, RESULT_REQ_PLS, PURGE, M_VALID}), 64'(0));
                    check({nm, "_data_zero"}, 64'(MAC_IN1 | MAC_IN2 | MAC_BIAS | M_DATA), 64'(0));
                    done = 1'b1;
                    aborted = 1'b1;
                end else if (cyc > 300) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_timeout: got BUSY=%0d after %0d cycles required 0", nm, BUSY, cyc);
                    done = 1'b1;
                    aborted = 1'b1;
                end
            end
        end
        START = 1'b0;
        S_VALID = 1'b0;
        if (!aborted) begin
            check({nm, "_mac_en_count"}, 64'(j_mac), 64'(len));
            check({nm, "_beats_accepted"}, 64'(acc), 64'(len));
            check({nm, "_bias_en_count"}, 64'(j_bias), 64'(ben));
            check({nm, "_req_count"}, 64'(j_req), 64'(1));
            check({nm, "_purge_count"}, 64'(j_purge), 64'(1));
            check({nm, "_busy_cycles"}, 64'(j_busy), 64'(exp_busy));
            check({nm, "_result_delivered"}, 64'(sb_q.size()), 64'(0));
            if (ben && len > 0)
                check({nm, "_bias_before_mac"}, 64'(j_bias_cyc < j_first_mac), 64'(1));
        end
        M_READY = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check({nm, "_idle_after"}, 64'(BUSY), 64'(0));
    endtask

    initial begin
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_ctrl", 64'({BUSY, S_READY, MAC_EN, BIAS_EN, RESULT_REQ_PLS, PURGE, M_VALID}), 64'(0));
        check("reset_data", 64'(MAC_IN1 | MAC_IN2 | MAC_BIAS | M_DATA), 64'(0));
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;

        //       name          len ben bias   tog hold sih abort expected            busy
        run_job("plain",       4,  0,  8'h00, 0,  0,   0,  0,    {CH{8'h60}},        13);
        run_job("bias",        4,  1,  8'h50, 0,  0,   0,  0,    {CH{8'h64}},        14);
        run_job("toggle",      4,  0,  8'h00, 1,  0,   0,  0,    {CH{8'h60}},        16);
        run_job("hold",        4,  0,  8'h00, 0,  10,  1,  0,    {CH{8'h60}},        23);
        run_job("len0_bias",   0,  1,  8'h50, 0,  0,   0,  0,    {CH{8'h50}},        10);
        run_job("abort",       4,  0,  8'h50, 0,  0,   0,  2,    {CH{8'h00}},        0);
        run_job("after_abort", 4,  0,  8'h00, 0,  0,   0,  0,    {CH{8'h60}},        13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/posit_mac_seq.md
Name: posit_mac_seq

Overview:
Parametrised dot-product sequencer for CH parallel posit_mac_f lanes.
- Accepts a valid/ready operand stream and runs length-LEN accumulations.
- Generates MAC_EN, BIAS_EN, RESULT_REQ_PLS and PURGE with fixed, latency-aware timing, then captures lane results into an output holding register.
- Replaces hand-timed control pulses with a reusable, back-pressured front end for CH-wide posit layers.

Parameters:
- N, 8, posit bit width per lane
- CH, 4, number of MAC lanes
- LEN_W, 13, width of length counter (max LEN = 2^LEN_W-1)
- ACC_LAT, 3, cycles from the last MAC_EN to quire settled
- RES_LAT, 2, cycles from RESULT_REQ_PLS to valid MAC_OUT

Ports:
- CLK  in  1  clock, all logic on posedge
- RESET  in  1  synchronous active-low reset
- START  in  1  begin a job when in IDLE (ignored otherwise)
- CFG_LEN  in  LEN_W  number of operand beats per job
- CFG_BIAS_EN  in  1  load BIAS into quires before accumulation
- BIAS  in  CH*N  per-lane bias, sampled at START
- BUSY  out  1  high in every state except IDLE
- S_VALID  in  1  operand beat valid
- S_READY  out  1  sequencer accepts beat
- S_IN1  in  CH*N  lane operands A
- S_IN2  in  CH*N  lane operands B
- MAC_IN1  out  CH*N  registered operands A to lanes
- MAC_IN2  out  CH*N  registered operands B to lanes
- MAC_BIAS  out  CH*N  latched bias to lanes
- MAC_EN  out  1  accumulate enable
- BIAS_EN  out  1  bias load strobe
- RESULT_REQ_PLS  out  1  one-cycle result request
- PURGE  out  1  one-cycle quire clear
- MAC_OUT  in  CH*N  lane results
- M_VALID  out  1  result held
- M_READY  in  1  consumer accepts result
- M_DATA  out  CH*N  captured results

Behaviour:
- Reset (RESET=0 at posedge): state IDLE; all outputs 0; counters 0. Applies mid-job: job discarded, no PURGE pulse. The first job after reset must start from cleared quires, so the lanes receive the same RESET.
- FSM states: IDLE, BIAS, ACC, DRAIN, REQ, WAIT, OUT, CLR.
- IDLE:
  - START=1 latches CFG_LEN to LEN, CFG_BIAS_EN and BIAS.
  - Next state is BIAS if bias is enabled; else ACC if LEN>0; else DRAIN.
- BIAS: BIAS_EN=1 for exactly one cycle, then go to ACC (or DRAIN if LEN=0).
- ACC:
  - S_READY=1.
  - Each S_VALID&S_READY beat registers S_IN1/S_IN2 into MAC_IN1/MAC_IN2, asserts MAC_EN in the following cycle, and increments cnt.
  - A cycle without a handshake gives MAC_EN=0 in the following cycle (bubble). MAC_IN1/MAC_IN2 hold their value.
  - When the beat with cnt==LEN-1 is accepted: S_READY drops the next cycle, state goes to DRAIN.
  - No beat beyond LEN is ever accepted.
- DRAIN:
  - Wait timer: ACC_LAT cycles counted from the cycle carrying the final MAC_EN.
  - With LEN=0, the timer counts from DRAIN entry.
  - Then go to REQ.
- REQ: RESULT_REQ_PLS=1 for one cycle, then go to WAIT.
- WAIT: after RES_LAT cycles, capture MAC_OUT into M_DATA, set M_VALID=1, go to OUT.
- OUT:
  - M_DATA and M_VALID are held stable until M_READY=1.
  - M_VALID may assert while M_READY is already high; the handshake completes that cycle.
  - On handshake: M_VALID=0, go to CLR.
- CLR: PURGE=1 for one cycle, then go to IDLE. BUSY falls on return to IDLE.
- START during a non-IDLE state is ignored; it is not queued.
- START and RESET=0 in the same cycle: reset wins.
- Control strobes (MAC_EN, BIAS_EN, RESULT_REQ_PLS, PURGE) are registered, and at most one is high in any cycle.
- Minimum job length in cycles: 1(+1 bias) + LEN + 1 + ACC_LAT + 1 + RES_LAT + 1 + 1, with no back-pressure.

Decomposition:
- Shared package posit_mac_pkg: FSM state enum, lane slice helper, posit constants (zero 0, NaR = 1 followed by N-1 zeros).
- One natural sub-module, posit_mac_seq_timer: loadable down-counter with done flag, reused for DRAIN and WAIT.
- posit_mac_f lane instances stay outside this block.

Test Plan:
- Bench: N=8, es=1, CH=4, ACC_LAT=3, RES_LAT=2, with four real posit_mac_f lanes attached.
- LEN=4, no bias, all operands 0x40 (1.0), S_VALID held high -> M_DATA all lanes 0x60 (4.0).
  - Exactly 4 MAC_EN cycles, then one RESULT_REQ_PLS, then one PURGE.
- LEN=4, bias 0x50 (2.0) on every lane, operands 1.0 -> M_DATA 0x64 (6.0).
  - BIAS_EN pulses once, before the first MAC_EN.
- LEN=4 with S_VALID toggling 1,0,1,0,... -> MAC_EN pattern mirrors the accepted beats; result is still 0x60.
  - S_READY is low in every cycle after the 4th acceptance.
- M_READY held low for 10 cycles in OUT -> M_VALID/M_DATA stable throughout; START pulses in this window are ignored; PURGE only follows the handshake.
- LEN=0 with bias 0x50 -> no MAC_EN; M_DATA 0x50 per lane.
- RESET low for one cycle mid-ACC (after 2 beats) -> all outputs 0, BUSY=0.
  - A following LEN=4 job of 1.0 operands returns 0x60.
